cla_pipe_addsub: RTL and testbench

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pipe_addsub.sv | 202 ++++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub -- pipelined carry-lookahead adder/subtractor with valid/ready
// handshaking on both sides.
//
// The WIDTH-bit datapath is cut into STAGES segments of WIDTH/STAGES bits. Each
// segment is added in one cycle by a chain of 4-bit carry-lookahead groups. The
// carry out of a segment is registered. The operand bits that are still waiting
// to be added, and the result bits that are already finished, travel alongside
// that carry in skew registers.
//
// Optional feature: define CLA_OVF_EN to add the Ov_o signed-overflow output.
// Without the macro, neither the port nor any overflow logic is built.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Ci_i,
    input  logic             Sub_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] S_o,
    output logic             Co_o,
`ifdef CLA_OVF_EN
    output logic             Ov_o,
`endif
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int SEG  = WIDTH / STAGES;   // bits resolved per stage
    localparam int NGRP = SEG / 4;          // 4-bit lookahead groups per segment

    // One segment addition built from 4-bit CLA groups. The carry between groups
    // comes from the group generate/propagate terms. Returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           ci
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] s;
        logic [3:0]     gg;
        logic [3:0]     pp;
        logic [3:0]     cc;
        logic           grp_g;
        logic           grp_p;
        logic           c;
        g = a & b;
        p = a ^ b;
        s = '0;
        c = ci;
        for (int k = 0; k < NGRP; k++) begin
            gg    = g[4*k +: 4];
            pp    = p[4*k +: 4];
            cc[0] = c;
            cc[1] = gg[0] | (pp[0] & c);
            cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
            cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & c);
            s[4*k +: 4] = pp ^ cc;
            grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0]);
            grp_p = &pp;
            c     = grp_g | (grp_p & c);
        end
        return {c, s};
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES:0]   adv;    // adv[j]: stage j register may capture this cycle
    logic [STAGES-1:0] vin;    // valid presented to stage j
    logic [STAGES-1:0] load;   // stage j captures a real beat

    // A stage advances when it is empty or its successor is advancing. This
    // collapses bubbles, so ready_o stays high while any stage is empty.
    always_comb begin
        adv         = '0;
        vin         = '0;
        load        = '0;
        vld_d       = vld_q;
        adv[STAGES] = ready_i;
        for (int j = STAGES - 1; j >= 0; j--) begin
            adv[j] = ~vld_q[j] | adv[j+1];
        end
        vin[0] = valid_i;
        for (int j = 1; j < STAGES; j++) begin
            vin[j] = vld_q[j-1];
        end
        for (int j = 0; j < STAGES; j++) begin
            load[j] = adv[j] & vin[j];
            if (adv[j]) begin
                vld_d[j] = vin[j];
            end
        end
    end

    // Per-stage valid bits. Reset drops every in-flight beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign ready_o = adv[0];
    assign valid_o = vld_q[STAGES-1];

    // ------------------------------------------------------------------
    // Datapath stages
    // ------------------------------------------------------------------
    for (genvar j = 0; j < STAGES; j++) begin : g_stg
        localparam int LO = j * SEG;        // first bit handled by this stage
        localparam int HI = LO + SEG;       // result bits complete after it
        localparam int UW = WIDTH - HI;     // operand bits still pending after it

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                cin;
        logic [SEG:0]        sum_seg;
        logic [HI-1:0]       res_d;
        logic [HI-1:0]       res_q;
        logic                cy_q;

        if (j == 0) begin : g_src
            // Subtract is A + ~B + 1; the inverted B travels down the skew
            // registers, so later stages are plain adders.
            assign a_in  = A_i;
            assign b_in  = Sub_i ? ~B_i : B_i;
            assign cin   = Sub_i | Ci_i;
            assign res_d = sum_seg[SEG-1:0];
        end else begin : g_src
            assign a_in  = g_stg[j-1].g_ops.a_q;
            assign b_in  = g_stg[j-1].g_ops.b_q;
            assign cin   = g_stg[j-1].cy_q;
            assign res_d = {sum_seg[SEG-1:0], g_stg[j-1].res_q};
        end

        assign sum_seg = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], cin);

        // Finished low result bits and the carry into the next segment.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                res_q <= '0;
                cy_q  <= 1'b0;
            end else if (load[j]) begin
                res_q <= res_d;
                cy_q  <= sum_seg[SEG];
            end
        end

        if (UW > 0) begin : g_ops
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;

            // Operand bits not yet added, skewed to meet their carry next stage.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load[j]) begin
                    a_q <= a_in[WIDTH-LO-1:SEG];
                    b_q <= b_in[WIDTH-LO-1:SEG];
                end
            end
        end

`ifdef CLA_OVF_EN
        if (j == STAGES - 1) begin : g_ovf
            logic c_msb;
            logic ov_q;

            // Carry into the MSB, recovered from the MSB sum bit.
            assign c_msb = a_in[SEG-1] ^ b_in[SEG-1] ^ sum_seg[SEG-1];

            // Signed overflow; it moves and stalls with the result.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    ov_q <= 1'b0;
                end else if (load[j]) begin
                    ov_q <= c_msb ^ sum_seg[SEG];
                end
            end
        end
`endif
    end

    assign S_o  = g_stg[STAGES-1].res_q;
    assign Co_o = g_stg[STAGES-1].cy_q;
`ifdef CLA_OVF_EN
    assign Ov_o = g_stg[STAGES-1].g_ovf.ov_q;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Testbench for cla_pipe_addsub. Instances: 16/2 (directed and random), 32/4 and
// 8/1 (random). Ov_o is checked when CLA_OVF_EN is defined.
module tb_cla_pipe_addsub;

`ifdef CLA_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0] a0, b0, s0;
    logic [31:0] a1, b1, s1;
    logic [7:0]  a2, b2, s2;
    logic [2:0]  ci_w, sub_w, vi_w, ri_w, co_w, vo_w, ro_w, ov_w;

    int checks   = 0;
    int failures = 0;

    cla_pipe_addsub #(.WIDTH(16), .STAGES(2)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .A_i(a0), .B_i(b0), .Ci_i(ci_w[0]),
        .Sub_i(sub_w[0]), .valid_i(vi_w[0]), .ready_o(ro_w[0]), .S_o(s0),
        .Co_o(co_w[0]),
`ifdef CLA_OVF_EN
        .Ov_o(ov_w[0]),
`endif
        .valid_o(vo_w[0]), .ready_i(ri_w[0]));

    cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .A_i(a1), .B_i(b1), .Ci_i(ci_w[1]),
        .Sub_i(sub_w[1]), .valid_i(vi_w[1]), .ready_o(ro_w[1]), .S_o(s1),
        .Co_o(co_w[1]),
`ifdef CLA_OVF_EN
        .Ov_o(ov_w[1]),
`endif
        .valid_o(vo_w[1]), .ready_i(ri_w[1]));

    cla_pipe_addsub #(.WIDTH(8), .STAGES(1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .A_i(a2), .B_i(b2), .Ci_i(ci_w[2]),
        .Sub_i(sub_w[2]), .valid_i(vi_w[2]), .ready_o(ro_w[2]), .S_o(s2),
        .Co_o(co_w[2]),
`ifdef CLA_OVF_EN
        .Ov_o(ov_w[2]),
`endif
        .valid_o(vo_w[2]), .ready_i(ri_w[2]));

`ifndef CLA_OVF_EN
    assign ov_w = 3'b000;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl [10];

    function automatic int wid(input int k);
        case (k)
            0:       return 16;
            1:       return 32;
            default: return 8;
        endcase
    endfunction

    // Reference: plain arithmetic on the operation's definition.
    // Result packed as {ov, co, 64-bit sum}.
    function automatic logic [65:0] ref_calc(input int w, input logic [63:0] a,
                                             input logic [63:0] b, input logic ci,
                                             input logic sub);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] bx;
        logic        sa, sb, sr, ov;
        mask = (65'd1 << w) - 65'd1;
        bx   = sub ? (~b & mask[63:0]) : b;
        full = {1'b0, a} + {1'b0, bx} + {64'd0, (sub ? 1'b1 : ci)};
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = full[w-1];
        ov   = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {ov & OVF_ON, full[w], full[63:0] & mask[63:0]};
    endfunction

    function automatic logic [65:0] cur_out(input int k);
        case (k)
            0:       return {ov_w[0], co_w[0], 48'd0, s0};
            1:       return {ov_w[1], co_w[1], 32'd0, s1};
            default: return {ov_w[2], co_w[2], 56'd0, s2};
        endcase
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic sub, input logic vi, input logic ri);
        case (k)
            0:       begin a0 = a[15:0]; b0 = b[15:0]; end
            1:       begin a1 = a[31:0]; b1 = b[31:0]; end
            default: begin a2 = a[7:0];  b2 = b[7:0];  end
        endcase
        ci_w[k]  = ci;
        sub_w[k] = sub;
        vi_w[k]  = vi;
        ri_w[k]  = ri;
    endtask

    // One beat into the 16/2 instance: accepted, not visible after one edge,
    // visible with the right value after two.
    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        drive(0, {48'd0, v.a}, {48'd0, v.b}, v.ci, v.sub, 1'b1, 1'b1);
        #1;
        check($sformatf("vec%0d_ready", idx), {65'd0, ro_w[0]}, 66'd1);
        @(negedge clk);
        drive(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check($sformatf("vec%0d_early", idx), {65'd0, vo_w[0]}, 66'd0);
        @(negedge clk);
        check($sformatf("vec%0d_valid", idx), {65'd0, vo_w[0]}, 66'd1);
        check($sformatf("vec%0d_result", idx), cur_out(0),
              {v.ov & OVF_ON, v.co, 48'd0, v.s});
    endtask

    // Four back-to-back beats; ready_i low for 3 cycles from the first output.
    task automatic seq_backpressure();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vs [4];
        logic [65:0] hold;
        logic [65:0] cur;
        logic        saw_full;
        logic        first_seen;
        logic        was_stall;
        int          nin, nout, stall_left, cyc;
        va = '{16'h1234, 16'hFFFF, 16'h8000, 16'h00F0};
        vb = '{16'h4321, 16'h0001, 16'h0001, 16'h0F0F};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1};
        saw_full = 1'b0; first_seen = 1'b0; was_stall = 1'b0; hold = '0;
        nin = 0; nout = 0; stall_left = 0; cyc = 0;
        while (nout < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            cur = cur_out(0);
            if (was_stall) check("bp_hold", cur, hold);
            if (vo_w[0] && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
            end
            if (nin < 4)
                drive(0, {48'd0, va[nin]}, {48'd0, vb[nin]}, 1'b0, vs[nin], 1'b1, stall_left == 0);
            else
                drive(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (!ro_w[0]) saw_full = 1'b1;
            if (vo_w[0] && ri_w[0]) begin
                check($sformatf("bp_out%0d", nout), cur,
                      ref_calc(16, {48'd0, va[nout]}, {48'd0, vb[nout]}, 1'b0, vs[nout]));
                nout++;
            end
            if (vi_w[0] && ro_w[0]) nin++;
            was_stall = vo_w[0] && !ri_w[0];
            hold      = cur;
        end
        check("bp_count", 66'(nout), 66'd4);
        check("bp_full", {65'd0, saw_full}, 66'd1);
        drive(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Two beats in flight, a one-cycle reset, then no stale output.
    task automatic seq_reset_mid();
        logic stale;
        @(negedge clk);
        drive(0, 64'h1111, 64'h2222, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 64'h3333, 64'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rm_inflight", {65'd0, vo_w[0]}, 66'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_valid", {65'd0, vo_w[0]}, 66'd0);
        check("rm_out", cur_out(0), 66'd0);
        check("rm_ready", {65'd0, ro_w[0]}, 66'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (vo_w[0]) stale = 1'b1;
        end
        check("rm_stale", {65'd0, stale}, 66'd0);
        apply_vec(99, tbl[0]);
    endtask

    // Random valid_i/ready_i/Sub_i against the reference model and an
    // in-order expectation queue; also checks outputs hold during stalls.
    task automatic run_random(input int k, input int nbeats);
        logic [65:0] q [$];
        logic [65:0] cur;
        logic [65:0] hold;
        logic [63:0] m, a, b;
        logic        was_stall, vi, ri, ci, sub;
        int          sent, got, cyc;
        m = (wid(k) == 64) ? '1 : ((64'd1 << wid(k)) - 64'd1);
        sent = 0; got = 0; cyc = 0; was_stall = 1'b0; hold = '0;
        while (got < nbeats && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            cur = cur_out(k);
            if (was_stall) check($sformatf("rand%0d_hold", k), cur, hold);
            a   = {$urandom(), $urandom()} & m;
            b   = {$urandom(), $urandom()} & m;
            ci  = $urandom_range(0, 1);
            sub = $urandom_range(0, 1);
            vi  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            ri  = ($urandom_range(0, 3) != 0);
            drive(k, a, b, ci, sub, vi, ri);
            #1;
            if (vo_w[k] && ri) begin
                if (q.size() == 0) begin
                    check($sformatf("rand%0d_unexpected", k), {65'd0, vo_w[k]}, 66'd0);
                end else begin
                    check($sformatf("rand%0d_beat%0d", k, got), cur, q.pop_front());
                end
                got++;
            end
            if (vi && ro_w[k]) begin
                q.push_back(ref_calc(wid(k), a, b, ci, sub));
                sent++;
            end
            was_stall = vo_w[k] && !ri;
            hold      = cur;
        end
        check($sformatf("rand%0d_delivered", k), 66'(got), 66'(nbeats));
        drive(k, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        tbl[0] = '{16'hBBBB, 16'hBBBB, 1'b1, 1'b0, 16'h7777, 1'b1, 1'b1};
        tbl[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[2] = '{16'h895E, 16'h0284, 1'b0, 1'b1, 16'h86DA, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d_valid", k), {65'd0, vo_w[k]}, 66'd0);
            check($sformatf("rst%0d_ready", k), {65'd0, ro_w[k]}, 66'd1);
            check($sformatf("rst%0d_out", k), cur_out(k), 66'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) apply_vec(i, tbl[i]);
        seq_backpressure();
        seq_reset_mid();

        run_random(0, 2000);
        run_random(1, 10000);
        run_random(2, 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
